// File: rtl/ram_bus_pkg.sv
// Shared types and constants for ram_bus_master and its bench.
// RAM_BUS_MASTER_WRITE_VERIFY_EN stretches write latency for the readback check.
package ram_bus_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD1  = 3'd2,
      RD2  = 3'd3,
      RESP = 3'd4,
      VRD1 = 3'd5,
      VRD2 = 3'd6
   } state_t;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // Acceptance edge to first cycle with rsp_valid high.
   localparam int RD_LAT = 3;
`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
   localparam int WR_LAT = 4;
`else
   localparam int WR_LAT = 2;
`endif

endpackage

// File: rtl/ram_bus_master.sv
// RAM initiator: valid/ready requests -> cs/rd/wr strobes; read 3 cycles, write 2 (4 with RAM_BUS_MASTER_WRITE_VERIFY_EN).
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module ram_bus_master
   import ram_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_cs,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data
);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state, state_nxt;
   req_t              req_q;
   logic [DATA_W-1:0] rdata_q;
   logic              drv_en;
   logic              accept;
   logic              capture;

   assign accept  = req_valid && (state == IDLE);
   assign capture = (state == RD2) || (state == VRD2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_q   <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            rdata_q <= '0;
         end
         if (capture) begin
            rdata_q <= mem_data;
         end
      end
   end

`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (state == VRD2) begin
         err_q <= (mem_data != req_q.wdata);
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_cs    = 1'b0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      drv_en    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = req_write ? WR : RD1;
            end
         end
         WR: begin
            mem_cs = 1'b1;
            mem_wr = 1'b1;
            drv_en = 1'b1;
`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
            state_nxt = VRD1;
`else
            state_nxt = RESP;
`endif
         end
         RD1: begin
            mem_cs    = 1'b1;
            mem_rd    = 1'b1;
            state_nxt = RD2;
         end
         RD2: begin
            mem_cs    = 1'b1;
            mem_rd    = 1'b1;
            state_nxt = RESP;
         end
`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
         VRD1: begin
            mem_cs    = 1'b1;
            mem_rd    = 1'b1;
            state_nxt = VRD2;
         end
         VRD2: begin
            mem_cs    = 1'b1;
            mem_rd    = 1'b1;
            state_nxt = RESP;
         end
`endif
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Enable is decoded from the registered state, so the bus is released the cycle after WR.
   assign mem_data  = drv_en ? req_q.wdata : {DATA_W{1'bz}};
   assign mem_addr  = req_q.addr;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a registered-read RAM model on the shared bus.
module tb_ram_bus_master;
   import ram_bus_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_write = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       mem_cs, mem_wr, mem_rd;
   logic [7:0] mem_addr;
   wire  [7:0] mem_data;

   int checks = 0;
   int fails = 0;
   int proto_errs = 0;

   ram_bus_master #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   // RAM model: write at the edge ending the strobe cycle, read registered and driven the next cycle.
   logic [7:0] ram [256] = '{default: 8'h00};
   logic [7:0] ram_q = 8'h00;
   logic       ram_drv = 1'b0;
   logic       stuck3 = 1'b0;
   logic [7:0] ref_mem [256] = '{default: 8'h00};

   always @(posedge clk) begin
      if (mem_cs && mem_wr) ram[mem_addr] <= stuck3 ? (mem_data & 8'hF7) : mem_data;
      ram_drv <= mem_cs && mem_rd;
      if (mem_cs && mem_rd) ram_q <= ram[mem_addr];
   end
   assign mem_data = ram_drv ? ram_q : 8'hzz;

   always @(negedge clk) begin
      if (!rst && mem_rd && mem_wr) proto_errs <= proto_errs + 1;
      if (!rst && mem_rd && dut.drv_en) proto_errs <= proto_errs + 1;
   end

   task automatic run_req(input logic w, input logic [7:0] a, input logic [7:0] d, input int hold,
                          output int lat, output logic [7:0] rd, output logic er);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      rd = rsp_rdata; er = rsp_err;
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL reset_rsp_rdata got=%h exp=00", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
      checks++; if ({mem_cs, mem_wr, mem_rd} !== 3'b000) begin fails++; $display("FAIL reset_strobes got=%b exp=000", {mem_cs, mem_wr, mem_rd}); end
      checks++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
      checks++; if (dut.drv_en !== 1'b0) begin fails++; $display("FAIL reset_bus_release got=%b exp=0", dut.drv_en); end
      rst = 1'b0;
   endtask

   task automatic test_write_read;
      int lat; logic [7:0] rd; logic er;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if ({mem_cs, mem_wr, mem_rd} !== 3'b110) begin fails++; $display("FAIL wr_strobes got=%b exp=110", {mem_cs, mem_wr, mem_rd}); end
      checks++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL wr_addr got=%h exp=10", mem_addr); end
      checks++; if (mem_data !== 8'hA5) begin fails++; $display("FAIL wr_data got=%h exp=a5", mem_data); end
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      checks++; if (lat !== WR_LAT) begin fails++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WR_LAT); end
`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
      checks++; if (rsp_rdata !== 8'hA5) begin fails++; $display("FAIL wr_rsp_rdata got=%h exp=a5", rsp_rdata); end
`else
      checks++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL wr_rsp_rdata got=%h exp=00", rsp_rdata); end
`endif
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (dut.drv_en !== 1'b0) begin fails++; $display("FAIL wr_bus_release got=%b exp=0", dut.drv_en); end
      ref_mem[8'h10] = 8'hA5;
      run_req(1'b0, 8'h10, 8'h00, 0, lat, rd, er);
      checks++; if (lat !== RD_LAT) begin fails++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RD_LAT); end
      checks++; if (rd !== 8'hA5) begin fails++; $display("FAIL rd_data got=%h exp=a5", rd); end
   endtask

   task automatic test_boundary;
      int lat; logic [7:0] rd; logic er;
      run_req(1'b1, 8'hFF, 8'h00, 0, lat, rd, er); ref_mem[8'hFF] = 8'h00;
      run_req(1'b1, 8'h00, 8'hFF, 0, lat, rd, er); ref_mem[8'h00] = 8'hFF;
      run_req(1'b0, 8'hFF, 8'h00, 0, lat, rd, er);
      checks++; if (rd !== 8'h00) begin fails++; $display("FAIL rd_addr_ff got=%h exp=00", rd); end
      run_req(1'b0, 8'h00, 8'h00, 0, lat, rd, er);
      checks++; if (rd !== 8'hFF) begin fails++; $display("FAIL rd_addr_00 got=%h exp=ff", rd); end
      checks++; if (lat !== RD_LAT) begin fails++; $display("FAIL rd_addr_00_latency got=%0d exp=%0d", lat, RD_LAT); end
   endtask

   task automatic test_backpressure;
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || req_ready !== 1'b0 || {mem_cs, mem_wr, mem_rd} !== 3'b000) begin
            fails++;
            $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b strb=%b exp v=1 d=a5 rdy=0 strb=000",
                     i, rsp_valid, rsp_rdata, req_ready, {mem_cs, mem_wr, mem_rd});
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if ({mem_cs, mem_rd} !== 2'b11) begin fails++; $display("FAIL mid_rd2_strobes got=%b exp=11", {mem_cs, mem_rd}); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({mem_cs, mem_wr, mem_rd} !== 3'b000 || dut.drv_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_state got strb=%b drv=%b v=%b rdy=%b exp strb=000 drv=0 v=0 rdy=1",
                  {mem_cs, mem_wr, mem_rd}, dut.drv_en, rsp_valid, req_ready);
      end
      seen = 0;
      repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
      checks++; if (seen !== 0) begin fails++; $display("FAIL mid_reset_no_rsp got=%0d exp=0", seen); end
   endtask

   task automatic test_random;
      int lat; logic [7:0] rd; logic er;
      logic w; logic [7:0] a, d;
      for (int i = 0; i < 1000; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         run_req(w, a, d, int'($urandom_range(0, 2)), lat, rd, er);
         if (w) begin
            ref_mem[a] = d;
            checks++; if (lat !== WR_LAT) begin fails++; $display("FAIL rand_wr_lat i=%0d got=%0d exp=%0d", i, lat, WR_LAT); end
`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
            checks++; if (rd !== d || er !== 1'b0) begin fails++; $display("FAIL rand_wr_verify i=%0d got=%h/%b exp=%h/0", i, rd, er, d); end
`else
            checks++; if (rd !== 8'h00 || er !== 1'b0) begin fails++; $display("FAIL rand_wr_rsp i=%0d got=%h/%b exp=00/0", i, rd, er); end
`endif
         end else begin
            checks++;
            if (rd !== ref_mem[a] || lat !== RD_LAT) begin
               fails++;
               $display("FAIL rand_rd i=%0d addr=%h got=%h lat=%0d exp=%h lat=%0d", i, a, rd, lat, ref_mem[a], RD_LAT);
            end
         end
      end
      checks++; if (proto_errs !== 0) begin fails++; $display("FAIL bus_protocol got=%0d exp=0", proto_errs); end
   endtask

`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
   task automatic test_verify;
      int lat; logic [7:0] rd; logic er;
      stuck3 = 1'b1;
      run_req(1'b1, 8'h05, 8'h08, 0, lat, rd, er);
      checks++; if (er !== 1'b1 || rd !== 8'h00) begin fails++; $display("FAIL verify_stuck got=%h/%b exp=00/1", rd, er); end
      run_req(1'b1, 8'h05, 8'h01, 0, lat, rd, er);
      checks++; if (er !== 1'b0 || rd !== 8'h01) begin fails++; $display("FAIL verify_clean got=%h/%b exp=01/0", rd, er); end
      stuck3 = 1'b0;
   endtask
`endif

   initial begin
      test_reset;
      test_write_read;
      test_boundary;
      test_backpressure;
      test_reset_mid;
      test_random;
`ifdef RAM_BUS_MASTER_WRITE_VERIFY_EN
      test_verify;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
